// File: rtl/pipe_pkg.sv
// Shared types for the hxd32 pipeline: forward selects, rd source codes,
// hazard-unit FSM states and scoreboard entries.
package pipe_pkg;

    localparam int unsigned RF_AW = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RD_SEL_ALU  = 2'd0;
    localparam logic [1:0] RD_SEL_DRAM = 2'd1;
    localparam logic [1:0] RD_SEL_PC   = 2'd2;
    localparam logic [1:0] RD_SEL_IMM  = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } hdu_state_t;

    typedef struct packed {
        logic             v;
        logic [RF_AW-1:0] addr;
        logic             is_load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hdu_fwd.sv
// Operand forward select for one EX source register against the
// MEM and WB scoreboard entries; the younger MEM entry wins.
module pipe_hdu_fwd
    import pipe_pkg::*;
(
    input  logic [RF_AW-1:0] rs_addr_i,
    input  sb_entry_t        mem_i,
    input  sb_entry_t        wb_i,
    output fwd_sel_t         sel_o
);

    logic rs_nz;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        rs_nz   = |rs_addr_i;
        mem_hit = rs_nz & mem_i.v & (mem_i.addr == rs_addr_i);
        wb_hit  = rs_nz & wb_i.v & (wb_i.addr == rs_addr_i) & ~mem_hit;
        sel_o   = FWD_NONE;
        unique case (1'b1)
            mem_hit: sel_o = FWD_MEM;
            wb_hit:  sel_o = FWD_WB;
            default: sel_o = FWD_NONE;
        endcase
        assert ($onehot0({mem_hit, wb_hit}))
            else $error("pipe_hdu_fwd: both hit paths active");
    end

endmodule

// File: rtl/pipe_hdu.sv
// Hazard detection and forwarding unit for the hxd32 5-stage pipe:
// EX forward selects, load-use stall, branch flush and wrong-path kill.
module pipe_hdu
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_ADDRW = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ex_rd_wr_en_i,
    input  logic [1:0]           ex_rd_wr_sel_i,
    input  logic [REG_ADDRW-1:0] ex_rd_wr_addr_i,
    input  logic [REG_ADDRW-1:0] ex_rs1_addr_i,
    input  logic [REG_ADDRW-1:0] ex_rs2_addr_i,
    input  logic                 ex_pc_wr_en_i,
    input  logic [REG_ADDRW-1:0] id_rs1_addr_i,
    input  logic [REG_ADDRW-1:0] id_rs2_addr_i,
    input  logic [1:0]           id_rs_used_i,
    output fwd_sel_t             fwd_a_sel_o,
    output fwd_sel_t             fwd_b_sel_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic                 ex_kill_o
);

    hdu_state_t state_q, state_d;
    sb_entry_t  sb_mem_q, sb_mem_d;
    sb_entry_t  sb_wb_q, sb_wb_d;

    logic ex_wr;
    logic ex_is_load;
    logic id_dep;
    logic flush;

    assign ex_kill_o = (state_q == KILL);

    always_comb begin
        ex_wr      = ex_rd_wr_en_i & ~ex_kill_o & (|ex_rd_wr_addr_i);
        ex_is_load = (ex_rd_wr_sel_i == RD_SEL_DRAM);
        id_dep     = (id_rs_used_i[0] & (id_rs1_addr_i == ex_rd_wr_addr_i))
                   | (id_rs_used_i[1] & (id_rs2_addr_i == ex_rd_wr_addr_i));

        sb_mem_d.v       = ex_wr;
        sb_mem_d.addr    = ex_rd_wr_addr_i;
        sb_mem_d.is_load = ex_wr & ex_is_load;
        sb_wb_d          = sb_mem_q;

        state_d = state_q;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ex_pc_wr_en_i & ~ex_kill_o) begin
                    flush   = 1'b1;
                    state_d = KILL;
                end
            end
            // Instr fetched past the branch is in EX now; it cannot redirect.
            KILL: state_d = RUN;
            default: state_d = RUN;
        endcase

        // A taken branch squashes the consumer, so it never needs the stall.
        stall_o = rst_n_i & ex_wr & ex_is_load & id_dep & ~ex_pc_wr_en_i;
        flush_o = rst_n_i & flush;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= RUN;
            sb_mem_q <= '0;
            sb_wb_q  <= '0;
        end else begin
            state_q  <= state_d;
            sb_mem_q <= sb_mem_d;
            sb_wb_q  <= sb_wb_d;
        end
    end

    pipe_hdu_fwd u_fwd_a (
        .rs_addr_i (ex_rs1_addr_i),
        .mem_i     (sb_mem_q),
        .wb_i      (sb_wb_q),
        .sel_o     (fwd_a_sel_o)
    );

    pipe_hdu_fwd u_fwd_b (
        .rs_addr_i (ex_rs2_addr_i),
        .mem_i     (sb_mem_q),
        .wb_i      (sb_wb_q),
        .sel_o     (fwd_b_sel_o)
    );

    a_no_mem_load_fwd : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(sb_mem_q.is_load &&
          ((fwd_a_sel_o == FWD_MEM) || (fwd_b_sel_o == FWD_MEM))))
        else $error("pipe_hdu: load forwarded from MEM (XLEN=%0d)", XLEN);

    a_no_stall_flush : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(stall_o && flush_o))
        else $error("pipe_hdu: stall and flush together");

    a_kill_single : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ex_kill_o |=> !ex_kill_o)
        else $error("pipe_hdu: ex_kill_o two cycles in a row");

endmodule
